outr_uart_tx: RTL and testbench
===============================

# outr_uart_tx

Serial output stage downstream of the basic-computer CPU's output register. Each strobed 16-bit OUTR word is captured into a small FIFO and shifted out on a UART-style line as two 8N1 bytes, low byte first. It gives the CPU a fire-and-forget output path with back-pressure (`fgo`) and a sticky overflow flag.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit time; legal range ≥ 2.
- `FIFO_DEPTH`, 4: word capacity; power of 2, ≥ 2.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  one-cycle strobe; the CPU has just loaded OUTR.
- `data_in`  in  16  OUTR word; sampled when `wr_en` = 1.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  1 while a frame is on the line (FSM not in IDLE).
- `fgo`  out  1  output flag; 1 when the FIFO is not full.
- `ovf`  out  1  sticky; set when a write is dropped; cleared only by reset.

## Operation
- **Reset values:** `reset` = 0 forces the following immediately, including mid-frame:
  - FIFO count 0; FSM IDLE.
  - `tx` = 1, `busy` = 0, `fgo` = 1, `ovf` = 0.
- **FIFO push:** `wr_en` = 1 with count < `FIFO_DEPTH` stores `data_in`.
- **Write while full:** `wr_en` = 1 with count = `FIFO_DEPTH` drops the word and sets `ovf`.
- **Full test:** fullness is judged on the registered count at the start of the cycle. A pop in the same cycle does not rescue the write.
- **Simultaneous push and pop:** both take effect; count is unchanged.
- **FSM states:** IDLE, START, DATA, PAR (present only with the parity feature), STOP.
- **IDLE:** if the FIFO is non-empty, pop the head word into the 16-bit holding register, set byte select to low, and go to START.
- **START:** `tx` = 0 for one bit time.
- **DATA:** 8 bits, LSB first, of the selected byte; 3-bit bit index.
- **PAR:** one bit time (see Configuration).
- **STOP:** `tx` = 1 for one bit time. Then:
  - if low byte: switch to high byte and go to START with no idle gap;
  - if high byte: go to IDLE.
- **Bit timer:** counts 0 to `CLKS_PER_BIT`−1. The state or bit advances on the terminal count.
- **FIFO pointers:** log2(`FIFO_DEPTH`) bits, wrapping naturally. The count register is log2(`FIFO_DEPTH`)+1 bits.
- **Word integrity:** the holding register is not affected by later pushes.

## Timing
- `wr_en` at edge N into an empty FIFO with the FSM in IDLE:
  - edge N+1: the word is popped and the FSM enters START;
  - `tx` falls in the cycle following edge N+1.
- `tx`, `busy` and `fgo` are registered outputs. `ovf` is set at the edge of the dropped write.
- **Word duration:** 20 × `CLKS_PER_BIT` cycles without parity; 22 × `CLKS_PER_BIT` with parity.
- **Back-to-back words:** the FSM spends exactly 1 cycle in IDLE between consecutive words when the FIFO is non-empty.
- **`busy`:** 1 from the START entry of a word to the IDLE entry after that word's final stop bit.
- **`fgo`:** deasserts on the edge where count reaches `FIFO_DEPTH`; reasserts on the edge of the pop that frees a slot.

## Configuration
- Macro `OUTR_UART_PARITY_EN`.
  - **Defined:** PAR state inserted after DATA, carrying the even-parity bit (XOR of the 8 data bits); frame is 11 bits.
  - **Undefined:** PAR state and its logic are absent; frame is 10 bits (8N1).

## Test plan
- **Single word:** `CLKS_PER_BIT`=4, write 0xA55A.
  - `tx` carries 0, bits of 0x5A LSB first, 1, then 0, bits of 0xA5, 1.
  - 80 cycles total; `busy` high throughout; `tx` idles high afterwards.
- **FIFO fill:** 6 back-to-back writes, 0x0001–0x0006, into an empty FIFO with depth 4.
  - Writes 1–5 are accepted: word 1 is popped at the second edge.
  - `fgo` = 0 after write 5. Write 6 is dropped and `ovf` = 1.
  - Serial output is 0x0001–0x0005 in order, with a 1-cycle IDLE between words.
- **Simultaneous push/pop:** FIFO holds 1 word and a write arrives on the IDLE pop edge.
  - Count stays 1 and both words are transmitted in order.
- **Reset mid-frame:** assert `reset` = 0 during the DATA state of a low byte.
  - `tx` = 1, `busy` = 0, `fgo` = 1 and `ovf` = 0 immediately, without waiting for a clock edge.
  - After release, with no writes, the line stays idle.
- **Parity (with `OUTR_UART_PARITY_EN`):** write 0x0107.
  - Low byte 0x07 has parity bit 1; high byte 0x01 has parity bit 1.
  - Word duration is 22 × `CLKS_PER_BIT`.
- **Pointer wrap:** stream 10 words spaced at 30 × `CLKS_PER_BIT`.
  - All 10 are received intact and `ovf` stays 0.

Source files
------------

// File: rtl/outr_uart_tx_if.sv
// OUTR write strobe/data and serial-line status bundle between the CPU and outr_uart_tx.
interface outr_uart_tx_if;
    logic        wr_en;
    logic [15:0] data_in;
    logic        tx;
    logic        busy;
    logic        fgo;
    logic        ovf;

    modport master (output wr_en, output data_in, input tx, input busy, input fgo, input ovf);
    modport slave  (input wr_en, input data_in, output tx, output busy, output fgo, output ovf);
endinterface

// File: rtl/outr_uart_tx.sv
// OUTR word FIFO feeding a UART line: each 16-bit word goes out as two 8N1 bytes, low byte first.
// Define OUTR_UART_PARITY_EN to insert an even-parity bit after each byte's data bits.
module outr_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    outr_uart_tx_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMR_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef OUTR_UART_PARITY_EN
        S_PAR,
`endif
        S_STOP
    } state_t;

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_fgo;
    logic          r_ovf;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [15:0]   r_hold;
    logic          r_hi;
    logic          r_tx;
    logic          r_busy;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_tick;
    logic [15:0]   w_head;
    logic [AW:0]   w_count_n;

    state_t        w_state_n;
    logic [TW-1:0] w_timer_n;
    logic [2:0]    w_bit_n;
    logic [15:0]   w_hold_n;
    logic          w_hi_n;
    logic [7:0]    w_byte;
    logic          w_tx_n;

    // Fullness is judged on the registered count, so a same-cycle pop never rescues a write.
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.wr_en & ~w_full;
    assign w_drop  = bus.wr_en & w_full;
    assign w_tick  = (r_timer == TMR_LAST);
    assign w_head  = r_mem[r_rd_ptr];

    always_comb begin
        w_count_n = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_n = r_count + CNT_ONE;
            2'b01:   w_count_n = r_count - CNT_ONE;
            default: w_count_n = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_fgo    <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_n;
            r_fgo   <= (w_count_n != CNT_FULL);
            r_ovf   <= r_ovf | w_drop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_hold    <= '0;
            r_hi      <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_timer   <= w_timer_n;
            r_bit_idx <= w_bit_n;
            r_hold    <= w_hold_n;
            r_hi      <= w_hi_n;
            r_tx      <= w_tx_n;
            r_busy    <= (w_state_n != S_IDLE);
        end
    end

    // Line level is derived from the next state so tx stays a registered output aligned with the FSM.
    always_comb begin
        w_state_n = r_state;
        w_timer_n = r_timer + TMR_ONE;
        w_bit_n   = r_bit_idx;
        w_hold_n  = r_hold;
        w_hi_n    = r_hi;
        w_pop     = 1'b0;
        w_tx_n    = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_timer_n = '0;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_hold_n  = w_head;
                    w_hi_n    = 1'b0;
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_timer_n = '0;
                    w_bit_n   = '0;
                    w_state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_timer_n = '0;
                    if (r_bit_idx == 3'd7) begin
`ifdef OUTR_UART_PARITY_EN
                        w_state_n = S_PAR;
`else
                        w_state_n = S_STOP;
`endif
                    end else begin
                        w_bit_n = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef OUTR_UART_PARITY_EN
            S_PAR: begin
                if (w_tick) begin
                    w_timer_n = '0;
                    w_state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    w_timer_n = '0;
                    if (!r_hi) begin
                        w_hi_n    = 1'b1;
                        w_state_n = S_START;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: begin
                w_timer_n = '0;
                w_state_n = S_IDLE;
            end
        endcase

        w_byte = w_hi_n ? w_hold_n[15:8] : w_hold_n[7:0];
        case (w_state_n)
            S_START: w_tx_n = 1'b0;
            S_DATA:  w_tx_n = w_byte[w_bit_n];
`ifdef OUTR_UART_PARITY_EN
            S_PAR:   w_tx_n = ^w_byte;
`endif
            default: w_tx_n = 1'b1;
        endcase
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.fgo  = r_fgo;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_outr_uart_tx.sv
// Self-checking bench for outr_uart_tx: a line receiver decodes tx and results are compared to expected words.
module tb_outr_uart_tx;
    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef OUTR_UART_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif
    localparam int unsigned WORD_CYC = 2 * FB * CPB;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   cyc;

    outr_uart_tx_if bus ();

    outr_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line receiver: samples each bit mid-period and pairs bytes into words (low byte first).
    logic [15:0] rx_q[$];
    int          rx_tq[$];
    int          rx_errs;
    bit          rx_act;
    bit          rx_hi;
    int unsigned rx_t;
    int          rx_start;
    int          rx_lo_start;
    logic [10:0] rx_sh;
    logic [7:0]  rx_lo;
    logic [7:0]  rx_b;
    logic [3:0]  rx_k;

    initial begin
        rx_errs = 0;
        rx_act  = 1'b0;
        rx_hi   = 1'b0;
        rx_t    = 0;
        rx_sh   = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                rx_act = 1'b0;
                rx_hi  = 1'b0;
            end else begin
                if (!rx_act) begin
                    if (bus.tx === 1'b0) begin
                        rx_act   = 1'b1;
                        rx_t     = 0;
                        rx_start = cyc;
                    end
                end else begin
                    rx_t++;
                end
                if (rx_act && (rx_t % CPB) == CPB / 2) begin
                    rx_k = 4'(rx_t / CPB);
                    rx_sh[rx_k] = bus.tx;
                    if (rx_k == 4'(FB - 1)) begin
                        rx_act = 1'b0;
                        rx_b   = rx_sh[8:1];
                        if (rx_sh[0] !== 1'b0 || rx_sh[FB-1] !== 1'b1) rx_errs++;
`ifdef OUTR_UART_PARITY_EN
                        if (rx_sh[9] !== ^rx_b) rx_errs++;
`endif
                        if (!rx_hi) begin
                            rx_lo       = rx_b;
                            rx_lo_start = rx_start;
                            rx_hi       = 1'b1;
                        end else begin
                            rx_q.push_back({rx_b, rx_lo});
                            rx_tq.push_back(rx_lo_start);
                            rx_hi = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        bus.wr_en = 1'b0;
        reset     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rx_q.delete();
        rx_tq.delete();
    endtask

    task automatic wait_rx(input int n, input int limit);
        for (int t = 0; t < limit && rx_q.size() < n; t++) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.wr_en   = 1'b0;
        bus.data_in = '0;
        reset       = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (bus.tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.fgo !== 1'b1)  begin n_fail++; $display("FAIL reset_fgo: got %b want 1", bus.fgo); end
        n_checks++; if (bus.ovf !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.tx !== 1'b1)   begin n_fail++; $display("FAIL reset_rel_tx: got %b want 1", bus.tx); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_rel_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single_word(input logic [15:0] w, input string name);
        bit         exp_bits[$];
        logic [7:0] b;
        repeat (2 * CPB) @(negedge clk);
        rx_q.delete();
        rx_tq.delete();
        for (int unsigned h = 0; h < 2; h++) begin
            b = (h == 0) ? w[7:0] : w[15:8];
            exp_bits.push_back(1'b0);
            for (int unsigned i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef OUTR_UART_PARITY_EN
            exp_bits.push_back(^b);
`endif
            exp_bits.push_back(1'b1);
        end
        bus.wr_en   = 1'b1;
        bus.data_in = w;
        @(negedge clk);
        bus.wr_en = 1'b0;
        n_checks++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL %s_latency_tx: got %b want 1", name, bus.tx); end
        for (int unsigned c = 0; c < WORD_CYC; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.tx !== exp_bits[c / CPB]) begin
                n_fail++; $display("FAIL %s_tx[%0d]: got %b want %b", name, c, bus.tx, exp_bits[c / CPB]);
            end
            n_checks++;
            if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy[%0d]: got %b want 1", name, c, bus.busy); end
        end
        @(negedge clk);
        n_checks++; if (bus.tx !== 1'b1)   begin n_fail++; $display("FAIL %s_end_tx: got %b want 1", name, bus.tx); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s_end_busy: got %b want 0", name, bus.busy); end
        n_checks++; if (rx_q.size() != 1)  begin n_fail++; $display("FAIL %s_rx_count: got %0d want 1", name, rx_q.size()); end
        if (rx_q.size() > 0) begin
            n_checks++; if (rx_q[0] !== w) begin n_fail++; $display("FAIL %s_rx_word: got %h want %h", name, rx_q[0], w); end
        end
        n_checks++; if (rx_errs != 0) begin n_fail++; $display("FAIL %s_frame_errs: got %0d want 0", name, rx_errs); end
    endtask

    task automatic test_fifo_fill();
        logic [15:0] w[6];
        apply_reset();
        for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
        for (int i = 0; i < 6; i++) begin
            bus.wr_en   = 1'b1;
            bus.data_in = w[i];
            @(negedge clk);
            if (i == 3) begin
                n_checks++; if (bus.fgo !== 1'b1) begin n_fail++; $display("FAIL fill_fgo_w4: got %b want 1", bus.fgo); end
            end
            if (i == 4) begin
                n_checks++; if (bus.fgo !== 1'b0) begin n_fail++; $display("FAIL fill_fgo_w5: got %b want 0", bus.fgo); end
                n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_w5: got %b want 0", bus.ovf); end
            end
            if (i == 5) begin
                n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL fill_ovf_w6: got %b want 1", bus.ovf); end
                n_checks++; if (bus.fgo !== 1'b0) begin n_fail++; $display("FAIL fill_fgo_w6: got %b want 0", bus.fgo); end
            end
        end
        bus.wr_en = 1'b0;
        wait_rx(5, 6 * WORD_CYC);
        n_checks++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL fill_rx_count: got %0d want 5", rx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) begin
                n_checks++; if (rx_q[i] !== w[i]) begin n_fail++; $display("FAIL fill_word%0d: got %h want %h", i, rx_q[i], w[i]); end
            end
            if (i > 0 && i < rx_tq.size()) begin
                n_checks++;
                if (rx_tq[i] - rx_tq[i-1] != int'(WORD_CYC) + 1) begin
                    n_fail++; $display("FAIL fill_gap%0d: got %0d want %0d", i, rx_tq[i] - rx_tq[i-1], WORD_CYC + 1);
                end
            end
        end
        repeat (WORD_CYC) @(negedge clk);
        n_checks++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL fill_dropped: got %0d words want 5", rx_q.size()); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fill_idle_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.fgo !== 1'b1)  begin n_fail++; $display("FAIL fill_idle_fgo: got %b want 1", bus.fgo); end
        n_checks++; if (bus.ovf !== 1'b1)  begin n_fail++; $display("FAIL fill_ovf_sticky: got %b want 1", bus.ovf); end
    endtask

    task automatic test_simul_push_pop();
        logic [15:0] w[6];
        logic        exp_fgo;
        apply_reset();
        for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
        bus.wr_en   = 1'b1;
        bus.data_in = w[0];
        @(negedge clk);
        bus.data_in = w[1];
        @(negedge clk);
        bus.wr_en = 1'b0;
        n_checks++; if (bus.fgo !== 1'b1) begin n_fail++; $display("FAIL pp_fgo_b: got %b want 1", bus.fgo); end
        repeat (3 * CPB) @(negedge clk);
        for (int i = 2; i < 5; i++) begin
            bus.wr_en   = 1'b1;
            bus.data_in = w[i];
            @(negedge clk);
            exp_fgo = (i < 4);
            n_checks++; if (bus.fgo !== exp_fgo) begin n_fail++; $display("FAIL pp_fgo_w%0d: got %b want %b", i, bus.fgo, exp_fgo); end
        end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL pp_ovf_pre: got %b want 0", bus.ovf); end
        bus.data_in = w[5];
        @(negedge clk);
        bus.wr_en = 1'b0;
        n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL pp_ovf_drop: got %b want 1", bus.ovf); end
        wait_rx(5, 7 * WORD_CYC);
        n_checks++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL pp_rx_count: got %0d want 5", rx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) begin
                n_checks++; if (rx_q[i] !== w[i]) begin n_fail++; $display("FAIL pp_word%0d: got %h want %h", i, rx_q[i], w[i]); end
            end
            if (i > 0 && i < rx_tq.size()) begin
                n_checks++;
                if (rx_tq[i] - rx_tq[i-1] != int'(WORD_CYC) + 1) begin
                    n_fail++; $display("FAIL pp_gap%0d: got %0d want %0d", i, rx_tq[i] - rx_tq[i-1], WORD_CYC + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] w;
        repeat (WORD_CYC) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            w = (i == 0) ? {8'($urandom_range(255)), 8'h00} : 16'($urandom);
            bus.wr_en   = 1'b1;
            bus.data_in = w;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        n_checks++; if (bus.tx !== 1'b0)   begin n_fail++; $display("FAIL mid_pre_tx: got %b want 0", bus.tx); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy: got %b want 1", bus.busy); end
        n_checks++; if (bus.fgo !== 1'b0)  begin n_fail++; $display("FAIL mid_pre_fgo: got %b want 0", bus.fgo); end
        n_checks++; if (bus.ovf !== 1'b1)  begin n_fail++; $display("FAIL mid_pre_ovf: got %b want 1", bus.ovf); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if (bus.tx !== 1'b1)   begin n_fail++; $display("FAIL mid_rst_tx: got %b want 1", bus.tx); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.fgo !== 1'b1)  begin n_fail++; $display("FAIL mid_rst_fgo: got %b want 1", bus.fgo); end
        n_checks++; if (bus.ovf !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_ovf: got %b want 0", bus.ovf); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rx_q.delete();
        rx_tq.delete();
        for (int c = 0; c < int'(30 * CPB); c++) begin
            @(negedge clk);
            n_checks++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL mid_idle_tx[%0d]: got %b want 1", c, bus.tx); end
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_busy: got %b want 0", bus.busy); end
        n_checks++; if (rx_q.size() != 0)  begin n_fail++; $display("FAIL mid_idle_rx: got %0d words want 0", rx_q.size()); end
    endtask

    task automatic test_pointer_wrap();
        logic [15:0] w[10];
        rx_q.delete();
        rx_tq.delete();
        for (int i = 0; i < 10; i++) begin
            w[i]        = 16'($urandom);
            bus.wr_en   = 1'b1;
            bus.data_in = w[i];
            @(negedge clk);
            bus.wr_en = 1'b0;
            n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf%0d: got %b want 0", i, bus.ovf); end
            repeat (30 * CPB - 1) @(negedge clk);
        end
        wait_rx(10, 2 * WORD_CYC);
        n_checks++; if (rx_q.size() != 10) begin n_fail++; $display("FAIL wrap_rx_count: got %0d want 10", rx_q.size()); end
        for (int i = 0; i < 10; i++) begin
            if (i < rx_q.size()) begin
                n_checks++; if (rx_q[i] !== w[i]) begin n_fail++; $display("FAIL wrap_word%0d: got %h want %h", i, rx_q[i], w[i]); end
            end
        end
        n_checks++; if (rx_errs != 0) begin n_fail++; $display("FAIL wrap_frame_errs: got %0d want 0", rx_errs); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_word(16'hA55A, "single");
        test_fifo_fill();
        test_simul_push_pop();
        test_reset_mid_frame();
        test_pointer_wrap();
`ifdef OUTR_UART_PARITY_EN
        test_single_word(16'h0107, "parity");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
